// File: rtl/iob_l2_burst_framer.sv
// Burst framer between the IOB switch and the L2 NoC: buffers beats in a small FIFO
// and marks burst boundaries on m_last from a configurable length or an early source last.
module iob_l2_burst_framer #(
    parameter int DATA_W = 256,
    parameter int LEN_W  = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_en,
    input  logic [LEN_W-1:0]  cfg_burst_len,
    input  logic              s_vld,
    input  logic              s_last,
    output logic              s_rdy,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_vld,
    output logic              m_last,
    input  logic              m_rdy,
    output logic [DATA_W-1:0] m_data,
    output logic              busy,
    output logic [15:0]       burst_cnt
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [LEN_W:0]   beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [15:0]      burst_cnt_q, burst_cnt_d;
    logic             init_q, init_d;
    logic [DATA_W:0]  mem_q [DEPTH];

    logic             empty, full, push, pop, head_last;
    logic [DATA_W:0]  head;
    logic [LEN_W-1:0] len_src;
    logic [LEN_W:0]   eff_len, eff_len_m1;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // init_q keeps s_rdy low until the first edge after reset release
    assign s_rdy     = init_q && cfg_en && !full;
    assign push      = s_vld && s_rdy;
    assign m_vld     = !empty;
    assign pop       = m_vld && m_rdy;
    assign head      = mem_q[rd_ptr_q[AW-1:0]];
    assign head_last = head[0];
    assign m_data    = head[DATA_W:1];
    assign busy      = !empty || (state_q == OPEN);
    assign burst_cnt = burst_cnt_q;

    always_comb begin
        len_src = (state_q == OPEN) ? len_q : cfg_burst_len;
        eff_len = {1'b0, len_src};
        if (len_src == '0) begin
            eff_len = {1'b1, {LEN_W{1'b0}}};
        end
        eff_len_m1 = eff_len - 1'b1;
        m_last     = !empty && (head_last || (beat_cnt_q == eff_len_m1));
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        len_d       = len_q;
        burst_cnt_d = burst_cnt_q;
        init_d      = 1'b1;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (m_last) begin
                state_d     = IDLE;
                beat_cnt_d  = '0;
                burst_cnt_d = burst_cnt_q + 16'd1;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
                if (state_q == IDLE) begin
                    state_d = OPEN;
                    len_d   = cfg_burst_len;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            len_q       <= '0;
            burst_cnt_q <= '0;
            init_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            len_q       <= len_d;
            burst_cnt_q <= burst_cnt_d;
            init_q      <= init_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {s_data, s_last};
        end
    end

endmodule

// File: tb/tb_iob_l2_burst_framer.sv
// Scoreboard bench for iob_l2_burst_framer: stimulus pushes expected beats into a queue,
// a negedge monitor pops and compares every output handshake.
module tb_iob_l2_burst_framer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cfg_en;
    logic [7:0]   cfg_burst_len;
    logic         s_vld, s_last, s_rdy;
    logic [255:0] s_data;
    logic         m_vld, m_last, m_rdy;
    logic [255:0] m_data;
    logic         busy;
    logic [15:0]  burst_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    logic [256:0] exp_q [$];

    always #5 clk = ~clk;

    iob_l2_burst_framer #(.DATA_W(256), .LEN_W(8), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_burst_len(cfg_burst_len),
        .s_vld(s_vld), .s_last(s_last), .s_rdy(s_rdy), .s_data(s_data),
        .m_vld(m_vld), .m_last(m_last), .m_rdy(m_rdy), .m_data(m_data),
        .busy(busy), .burst_cnt(burst_cnt)
    );

    function automatic logic [255:0] mk(input int tid, input int idx);
        logic [7:0]  t;
        logic [15:0] i;
        t = 8'(tid);
        i = 16'(idx);
        return {8{t, 8'hA5, i}};
    endfunction

    task automatic chk(input string name, input logic [256:0] act, input logic [256:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one beat and record its expected framing once it is accepted
    task automatic push(input int tid, input int idx, input logic src_last, input logic exp_last);
        int waited;
        s_vld  = 1'b1;
        s_data = mk(tid, idx);
        s_last = src_last;
        waited = 0;
        @(negedge clk);
        while (!s_rdy && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!s_rdy) begin
            chk("push_timeout", 257'(s_rdy), 257'(1));
        end else begin
            exp_q.push_back({mk(tid, idx), exp_last});
        end
        @(posedge clk);
        #1;
        s_vld  = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic wait_drain(input bit need_idle);
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || (need_idle && busy)) && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk("drain_left", 257'(exp_q.size()), 257'(0));
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops on every handshake and checks hold stability while stalled
    logic         prev_stall = 1'b0;
    logic [256:0] prev_out;
    always @(negedge clk) begin
        if (prev_stall && m_vld) begin
            chk("hold", {m_data, m_last}, prev_out);
        end
        if (m_vld && m_rdy) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_beat: got %0h expected none", {m_data, m_last});
            end else begin
                chk("beat", {m_data, m_last}, exp_q.pop_front());
            end
        end
        prev_stall = m_vld && !m_rdy;
        prev_out   = {m_data, m_last};
    end

    initial begin
        rst_n = 1'b0;
        cfg_en = 1'b1;
        cfg_burst_len = 8'd4;
        s_vld = 1'b0;
        s_last = 1'b0;
        s_data = '0;
        m_rdy = 1'b1;

        #13;
        chk("rst_m_vld", 257'(m_vld), 257'(0));
        chk("rst_m_last", 257'(m_last), 257'(0));
        chk("rst_s_rdy", 257'(s_rdy), 257'(0));
        chk("rst_busy", 257'(busy), 257'(0));
        chk("rst_burst_cnt", 257'(burst_cnt), 257'(0));
        #4;
        rst_n = 1'b1;
        #1;
        chk("s_rdy_after_release", 257'(s_rdy), 257'(0));
        @(posedge clk);
        #1;

        // Fixed length 4, 8 beats
        for (int i = 0; i < 8; i++) push(1, i, 1'b0, (i == 3) || (i == 7));
        wait_drain(1'b1);
        chk("t1_burst_cnt", 257'(burst_cnt), 257'(2));
        chk("t1_busy", 257'(busy), 257'(0));

        // Source last on beat index 1 shortens the first burst
        for (int i = 0; i < 6; i++) push(2, i, (i == 1), (i == 1) || (i == 5));
        wait_drain(1'b1);
        chk("t2_burst_cnt", 257'(burst_cnt), 257'(4));

        // Back-pressure: fill the FIFO, then release
        m_rdy = 1'b0;
        for (int i = 0; i < 4; i++) push(3, i, 1'b0, (i == 3));
        @(negedge clk);
        chk("t3_full_s_rdy", 257'(s_rdy), 257'(0));
        chk("t3_m_vld", 257'(m_vld), 257'(1));
        @(posedge clk);
        #1;
        m_rdy = 1'b1;
        push(3, 4, 1'b1, 1'b1);
        wait_drain(1'b1);
        chk("t3_burst_cnt", 257'(burst_cnt), 257'(6));

        // Length 0 means 256 beats
        cfg_burst_len = 8'd0;
        for (int i = 0; i < 256; i++) push(4, i, 1'b0, (i == 255));
        wait_drain(1'b1);
        chk("t4_burst_cnt", 257'(burst_cnt), 257'(7));

        // Length 1: every beat is its own burst
        cfg_burst_len = 8'd1;
        for (int i = 0; i < 3; i++) push(5, i, 1'b0, 1'b1);
        wait_drain(1'b1);
        chk("t4_len1_burst_cnt", 257'(burst_cnt), 257'(10));
        chk("t4_len1_busy", 257'(busy), 257'(0));

        // Length change while a burst is open
        cfg_burst_len = 8'd4;
        push(6, 0, 1'b0, 1'b0);
        wait_drain(1'b0);
        chk("t5_open_busy", 257'(busy), 257'(1));
        cfg_burst_len = 8'd2;
        for (int i = 1; i < 6; i++) push(6, i, 1'b0, (i == 3) || (i == 5));
        wait_drain(1'b1);
        chk("t5_burst_cnt", 257'(burst_cnt), 257'(12));

        // Reset mid-burst with beats buffered
        cfg_burst_len = 8'd4;
        push(7, 0, 1'b0, 1'b0);
        push(7, 1, 1'b0, 1'b0);
        wait_drain(1'b0);
        m_rdy = 1'b0;
        push(7, 2, 1'b0, 1'b0);
        push(7, 3, 1'b0, 1'b1);
        chk("t6_pre_m_vld", 257'(m_vld), 257'(1));
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("t6_rst_m_vld", 257'(m_vld), 257'(0));
        chk("t6_rst_burst_cnt", 257'(burst_cnt), 257'(0));
        chk("t6_rst_busy", 257'(busy), 257'(0));
        chk("t6_rst_s_rdy", 257'(s_rdy), 257'(0));
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        m_rdy = 1'b1;
        for (int i = 0; i < 4; i++) push(8, i, 1'b0, (i == 3));
        wait_drain(1'b1);
        chk("t6_burst_cnt", 257'(burst_cnt), 257'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/iob_l2_burst_framer.md
IOB_L2_BURST_FRAMER -- requirements
Module: iob_l2_burst_framer

Interface
REQ-001 SHALL have parameter DATA_W, default 256, the stream data width in bits.
REQ-002 SHALL have parameter LEN_W, default 8, the burst-length field width.
REQ-003 SHALL have parameter DEPTH, default 4, the FIFO entry count (power of 2, minimum 2).
REQ-004 SHALL have port clk, input, 1, the clock.
REQ-005 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-006 SHALL have port cfg_en, input, 1, which enables input acceptance.
REQ-007 SHALL have port cfg_burst_len, input, LEN_W, giving beats per burst; 0 means 2^LEN_W.
REQ-008 SHALL have ports s_vld (input, 1), s_last (input, 1), s_rdy (output, 1) and s_data (input, DATA_W), forming the upstream stream from the IOB switch.
REQ-009 SHALL have ports m_vld (output, 1), m_last (output, 1), m_rdy (input, 1) and m_data (output, DATA_W), forming the downstream stream to the L2 NoC.
REQ-010 SHALL have port busy, output, 1, asserted when the FIFO is non-empty or a burst is open.
REQ-011 SHALL have port burst_cnt, output, 16, counting completed bursts and wrapping at 2^16.

Function
REQ-012 Input handshake SHALL occur when s_vld&&s_rdy; s_rdy = cfg_en && !full; s_rdy SHALL NOT depend on m_rdy.
REQ-013 FIFO SHALL store {s_data, s_last} per accepted beat; order preserved; no beat dropped or duplicated.
REQ-014 Output SHALL be registered: a beat accepted at edge N into an empty FIFO SHALL appear on m_vld/m_data after edge N (1-cycle latency).
REQ-015 m_vld = !empty; m_data/m_last SHALL be held stable while m_vld && !m_rdy.
REQ-016 Output handshake SHALL occur when m_vld&&m_rdy.
REQ-017 Simultaneous push and pop SHALL leave occupancy unchanged; the full flag SHALL prevent push even if pop occurs the same cycle.
REQ-018 The FSM SHALL have states IDLE and OPEN.
REQ-019 IDLE->OPEN SHALL occur on an output handshake whose beat is not m_last; len_q SHALL be latched from cfg_burst_len on that first beat.
REQ-020 OPEN->IDLE SHALL occur on an output handshake with m_last; beat counter SHALL clear to 0 and burst_cnt SHALL increment by 1.
REQ-021 A single-beat burst (effective length 1, or stored last on the first beat) SHALL stay in IDLE and still increment burst_cnt.
REQ-022 beat_cnt (LEN_W+1 bits) SHALL increment per output handshake while not last.
REQ-023 m_last SHALL equal (beat_cnt == eff_len-1) OR the stored source-last flag of the head entry.
REQ-024 eff_len SHALL be the latched len_q while OPEN and live cfg_burst_len while IDLE; 0 SHALL map to 2^LEN_W.
REQ-025 A source last SHALL terminate the burst early (short burst); the counter SHALL restart at the next beat.
REQ-026 A cfg_burst_len change while OPEN SHALL NOT affect the current burst.
REQ-027 Deasserting cfg_en SHALL block input only; buffered beats SHALL continue to drain; the FSM SHALL be unaffected.
REQ-028 FIFO pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished by an extra pointer bit.
REQ-029 burst_cnt SHALL wrap 0xFFFF->0x0000 without a flag.

Reset
REQ-030 On rst_n low, asynchronously: FIFO empty, pointers 0, FSM IDLE, beat_cnt 0, len_q 0, burst_cnt 0, m_vld 0, m_last 0, s_rdy 0, busy 0.
REQ-031 m_data SHALL be don't-care in reset; the data array SHALL NOT be reset.
REQ-032 Reset mid-burst SHALL discard all buffered beats and the open burst; the first post-reset beat SHALL start a new burst.
REQ-033 s_rdy SHALL rise no earlier than the first clk edge after rst_n deasserts (with cfg_en=1).

Verification
REQ-034 len=4, m_rdy=1, push 8 beats D0..D7, s_last=0 -> m_last on D3 and D7, burst_cnt=2, busy=0 after drain.
REQ-035 len=4, push 6 beats with s_last on beat 2 -> m_last on D1, D5; burst_cnt=2 (short burst of 2, then burst of 4).
REQ-036 m_rdy=0, push 5 beats with DEPTH=4 -> s_rdy=0 after 4 accepts; release m_rdy -> D0..D4 in order, no loss.
REQ-037 len=0 (256) with 256-beat stream -> single m_last on beat 255; len=1 -> m_last on every beat, FSM stays IDLE.
REQ-038 len=4, switch cfg_burst_len to 2 after beat 1 -> current burst ends at beat 3; next ends at beat 5.
REQ-039 Assert rst_n low after beat 2 of a 4-beat burst with 2 beats buffered -> m_vld=0, burst_cnt=0; new 4-beat burst after release frames correctly.
